// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   arb_state_e      : arbiter FSM state encoding
//   StarveLimDefault : default count of consecutive DM grants before a waiting fetch wins
//   StarveCntMax     : saturation value of the starvation counter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDmBusy = 2'd1,
    StIfBusy = 2'd2
  } arb_state_e;

  localparam int unsigned StarveLimDefault = 4;
  localparam logic [3:0]  StarveCntMax     = 4'd15;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified instruction/data memory between the fetch stage (IF)
// and the memory stage (DM), sequences each access with a ready handshake, and raises a
// pipeline-wide stall while any request is outstanding.
//
// Ports:
//   clk, start        : rising-edge clock; synchronous active-low reset (start=0 resets)
//   flush             : PC redirect; drops the pending or in-flight fetch response
//   if_req/if_addr    : fetch request (level, held until if_valid) and address
//   if_rdata/if_valid : registered fetch data and its one-cycle valid pulse
//   dm_rd/dm_wr       : load / store request (level, mutually exclusive)
//   dm_addr/dm_wdata  : data address and store data
//   dm_rdata/dm_valid : registered load data and one-cycle done pulse (loads and stores)
//   mem_*             : registered request toward the memory macro; mem_rdata is taken
//                       in the cycle mem_ready=1
//   stall             : combinational freeze of PC and IF/ID
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned width      = 32,
  parameter int unsigned STARVE_LIM = StarveLimDefault
) (
  input  logic             clk,
  input  logic             start,
  input  logic             flush,
  input  logic             if_req,
  input  logic [width-1:0] if_addr,
  output logic [width-1:0] if_rdata,
  output logic             if_valid,
  input  logic             dm_rd,
  input  logic             dm_wr,
  input  logic [width-1:0] dm_addr,
  input  logic [width-1:0] dm_wdata,
  output logic [width-1:0] dm_rdata,
  output logic             dm_valid,
  output logic             mem_req,
  output logic             mem_we,
  output logic [width-1:0] mem_addr,
  output logic [width-1:0] mem_wdata,
  input  logic [width-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             stall
);

  localparam logic [3:0] StarveLim = 4'(STARVE_LIM);

  arb_state_e       r_state;
  arb_state_e       w_state_next;
  logic [3:0]       r_starve_cnt;
  logic             r_drop_if;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [width-1:0] r_mem_addr;
  logic [width-1:0] r_mem_wdata;
  logic [width-1:0] r_if_rdata;
  logic [width-1:0] r_dm_rdata;
  logic             r_if_valid;
  logic             r_dm_valid;

  logic w_dm_pend;
  logic w_if_pend;
  logic w_turnaround;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_done;

  assign w_dm_pend = dm_rd | dm_wr;
  assign w_if_pend = if_req & ~flush;
  // A requester still sees its request high in the cycle its valid pulses. Granting nothing
  // in that cycle keeps a stale request from being served twice and lets a DM request that
  // is re-asserted back to back compete against a waiting fetch, which the starvation
  // counter then bounds.
  assign w_turnaround = r_if_valid | r_dm_valid;

  always_ff @(posedge clk) begin
    if (!start) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_dm   = 1'b0;
    w_grant_if   = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_turnaround) begin
          if (w_dm_pend && (!w_if_pend || (r_starve_cnt < StarveLim))) begin
            w_grant_dm   = 1'b1;
            w_state_next = StDmBusy;
          end else if (w_if_pend) begin
            w_grant_if   = 1'b1;
            w_state_next = StIfBusy;
          end
        end
      end
      StDmBusy, StIfBusy: begin
        if (mem_ready) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!start) begin
      r_starve_cnt <= '0;
      r_drop_if    <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_valid   <= 1'b0;
      r_dm_valid   <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;

      if (w_grant_dm) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= dm_wr;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
      end else if (w_grant_if) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= 1'b0;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= '0;
      end

      if (w_done) begin
        r_mem_req <= 1'b0;
        if (r_state == StDmBusy) begin
          r_dm_valid <= 1'b1;
          if (!r_mem_we) begin
            r_dm_rdata <= mem_rdata;
          end
        end else begin
          // A flush earlier in the access or in this very cycle kills the response.
          if (!(r_drop_if || flush)) begin
            r_if_valid <= 1'b1;
            r_if_rdata <= mem_rdata;
          end
          r_drop_if <= 1'b0;
        end
      end else if ((r_state == StIfBusy) && flush) begin
        r_drop_if <= 1'b1;
      end

      if (!w_if_pend || w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_grant_dm && (r_starve_cnt != StarveCntMax)) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_valid  = r_if_valid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_valid  = r_dm_valid;

  assign stall = start & ((if_req & ~r_if_valid) | (w_dm_pend & ~r_dm_valid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a table of per-cycle input/expected-output records followed by
// hand-written sequences for starvation, flush, and reset in the middle of an access.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z = 32'h0;

  typedef struct packed {
    logic        st, fl, ifr;
    logic [31:0] ifa;
    logic        dr, dw;
    logic [31:0] da, dwd, mrd;
    logic        mry;
  } in_t;

  typedef struct packed {
    logic        req, we;
    logic [31:0] addr, wd;
    logic        ifv;
    logic [31:0] ifd;
    logic        dmv;
    logic [31:0] dmd;
    logic        stl;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        start, flush, if_req, if_valid, dm_rd, dm_wr, dm_valid;
  logic        mem_req, mem_we, mem_ready, stall;
  logic [31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_bad = 0;

  mem_port_arbiter #(.width(32), .STARVE_LIM(4)) dut (
    .clk(clk), .start(start), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall(stall)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic st, fl, ifr, input logic [31:0] ifa,
                              input logic dr, dw, input logic [31:0] da, dwd, mrd,
                              input logic mry, input logic req, we,
                              input logic [31:0] addr, wd, input logic ifv,
                              input logic [31:0] ifd, input logic dmv,
                              input logic [31:0] dmd, input logic stl);
    vec_t v;
    v.i = '{st: st, fl: fl, ifr: ifr, ifa: ifa, dr: dr, dw: dw, da: da, dwd: dwd, mrd: mrd,
            mry: mry};
    v.o = '{req: req, we: we, addr: addr, wd: wd, ifv: ifv, ifd: ifd, dmv: dmv, dmd: dmd,
            stl: stl};
    return v;
  endfunction

  task automatic drive(input in_t x);
    start = x.st; flush = x.fl; if_req = x.ifr; if_addr = x.ifa;
    dm_rd = x.dr; dm_wr = x.dw; dm_addr = x.da; dm_wdata = x.dwd;
    mem_rdata = x.mrd; mem_ready = x.mry;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[19];
  logic [31:0] grants[$];
  out_t act;

  initial begin
    vecs[0]  = mk(L,L,H,32'h10, H,L,Z,Z,Z,H,  L,L,Z,Z, L,Z, L,Z, L);
    vecs[1]  = mk(H,L,H,32'h10, L,L,Z,Z,32'h00500093,H,  L,L,Z,Z, L,Z, L,Z, H);
    vecs[2]  = mk(H,L,H,32'h10, L,L,Z,Z,32'h00500093,H,  H,L,32'h10,Z, L,Z, L,Z, H);
    vecs[3]  = mk(H,L,H,32'h10, L,L,Z,Z,32'h00500093,H,
                  L,L,32'h10,Z, H,32'h00500093, L,Z, L);
    vecs[4]  = mk(H,L,L,Z, L,L,Z,Z,Z,H,  L,L,32'h10,Z, L,32'h00500093, L,Z, L);
    vecs[5]  = mk(H,L,H,32'h14, H,L,32'h200,Z,32'hAAAA0001,H,
                  L,L,32'h10,Z, L,32'h00500093, L,Z, H);
    vecs[6]  = mk(H,L,H,32'h14, H,L,32'h200,Z,32'hAAAA0001,H,
                  H,L,32'h200,Z, L,32'h00500093, L,Z, H);
    vecs[7]  = mk(H,L,H,32'h14, H,L,32'h200,Z,32'h11110002,H,
                  L,L,32'h200,Z, L,32'h00500093, H,32'hAAAA0001, H);
    vecs[8]  = mk(H,L,H,32'h14, L,L,Z,Z,32'h11110002,H,
                  L,L,32'h200,Z, L,32'h00500093, L,32'hAAAA0001, H);
    vecs[9]  = mk(H,L,H,32'h14, L,L,Z,Z,32'h11110002,H,
                  H,L,32'h14,Z, L,32'h00500093, L,32'hAAAA0001, H);
    vecs[10] = mk(H,L,H,32'h14, L,L,Z,Z,32'h11110002,H,
                  L,L,32'h14,Z, H,32'h11110002, L,32'hAAAA0001, L);
    vecs[11] = mk(H,L,L,Z, L,L,Z,Z,Z,H,  L,L,32'h14,Z, L,32'h11110002, L,32'hAAAA0001, L);
    vecs[12] = mk(H,L,L,Z, L,H,32'h40,32'hDEADBEEF,32'h12345678,L,
                  L,L,32'h14,Z, L,32'h11110002, L,32'hAAAA0001, H);
    for (int k = 13; k <= 15; k++) begin
      vecs[k] = mk(H,L,L,Z, L,H,32'h40,32'hDEADBEEF,32'h12345678,L,
                   H,H,32'h40,32'hDEADBEEF, L,32'h11110002, L,32'hAAAA0001, H);
    end
    vecs[16] = mk(H,L,L,Z, L,H,32'h40,32'hDEADBEEF,32'h12345678,H,
                  H,H,32'h40,32'hDEADBEEF, L,32'h11110002, L,32'hAAAA0001, H);
    vecs[17] = mk(H,L,L,Z, L,H,32'h40,32'hDEADBEEF,32'h12345678,H,
                  L,H,32'h40,32'hDEADBEEF, L,32'h11110002, H,32'hAAAA0001, L);
    vecs[18] = mk(H,L,L,Z, L,L,Z,Z,Z,H,
                  L,H,32'h40,32'hDEADBEEF, L,32'h11110002, L,32'hAAAA0001, L);

    drive(vecs[0].i);
    repeat (2) @(posedge clk);
    #1;

    // Table: fetch latency, DM-before-IF ordering, delayed-ready store.
    for (int k = 0; k < 19; k++) begin
      drive(vecs[k].i);
      @(negedge clk);
      act = '{req: mem_req, we: mem_we, addr: mem_addr, wd: mem_wdata, ifv: if_valid,
              ifd: if_rdata, dmv: dm_valid, dmd: dm_rdata, stl: stall};
      n_vec++;
      if (act !== vecs[k].o) begin
        n_bad++;
        $display("FAIL vec%0d: got %h, want %h (req,we,addr,wdata,ifv,ifd,dmv,dmd,stall)",
                 k, act, vecs[k].o);
      end
      next_cycle();
    end

    // Starvation: fetch held while loads keep coming; expect 4 DM grants then the fetch.
    start = H; flush = L; if_req = H; if_addr = 32'h80; dm_rd = H; dm_wr = L;
    dm_addr = 32'h300; dm_wdata = Z; mem_rdata = 32'h5; mem_ready = H;
    begin
      logic prev_req;
      prev_req = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (mem_req && !prev_req) grants.push_back(mem_addr);
        prev_req = mem_req;
        if (grants.size() == 5) break;
        next_cycle();
      end
    end
    check("starve_grant_count", 32'(grants.size()), 32'd5);
    if (grants.size() == 5) begin
      for (int g = 0; g < 4; g++) check("starve_dm_grant", grants[g], 32'h300);
      check("starve_if_grant", grants[4], 32'h80);
      check("starve_cnt_cleared", 32'(dut.r_starve_cnt), 32'd0);
      next_cycle();
      if_req = L; dm_rd = L;
      @(negedge clk);
      check("starve_if_valid", 32'(if_valid), 32'd1);
      check("starve_if_rdata", if_rdata, 32'h5);
    end
    next_cycle();
    next_cycle();

    // Flush in IF_BUSY with ready delayed: access completes silently.
    if_req = H; if_addr = 32'h90; mem_ready = L; mem_rdata = 32'hBAD0BAD0;
    next_cycle();
    flush = H;
    @(negedge clk);
    check("flush_mem_req", 32'(mem_req), 32'd1);
    check("flush_mem_addr", mem_addr, 32'h90);
    next_cycle();
    flush = L;
    next_cycle();
    mem_ready = H;
    next_cycle();
    if_req = L; mem_ready = L;
    @(negedge clk);
    check("flush_no_valid", 32'(if_valid), 32'd0);
    check("flush_rdata_kept", if_rdata, 32'h5);
    check("flush_req_dropped", 32'(mem_req), 32'd0);
    check("flush_state_idle", 32'(dut.r_state), 32'(StIdle));
    next_cycle();
    @(negedge clk);
    check("flush_no_late_valid", 32'(if_valid), 32'd0);

    // Flush landing on the completion cycle.
    if_req = H; if_addr = 32'h94; mem_ready = H; mem_rdata = 32'hCAFE0001;
    next_cycle();
    flush = H;
    next_cycle();
    flush = L; if_req = L;
    @(negedge clk);
    check("flush_done_no_valid", 32'(if_valid), 32'd0);
    check("flush_done_rdata_kept", if_rdata, 32'h5);
    next_cycle();

    // Reset in the middle of a load.
    dm_rd = H; dm_addr = 32'h500; mem_ready = L; mem_rdata = 32'h0000FEED;
    next_cycle();
    @(negedge clk);
    check("rst_busy_req", 32'(mem_req), 32'd1);
    check("rst_busy_addr", mem_addr, 32'h500);
    next_cycle();
    start = L; mem_ready = H;
    @(negedge clk);
    check("rst_stall_gated", 32'(stall), 32'd0);
    next_cycle();
    start = H; dm_rd = L; mem_ready = L;
    @(negedge clk);
    check("rst_dm_valid", 32'(dm_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_dm_rdata", dm_rdata, 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    next_cycle();

    // Service resumes: fetch valid lands two cycles after the request cycle.
    if_req = H; if_addr = 32'h20; mem_ready = H; mem_rdata = 32'h77;
    begin
      int lat;
      lat = -1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (if_valid) begin
          lat = c;
          break;
        end
        next_cycle();
      end
      check("post_rst_latency", 32'(lat), 32'd2);
      check("post_rst_if_rdata", if_rdata, 32'h77);
    end
    next_cycle();
    if_req = L;
    next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the Fetch stage (IF) and the Memory stage (DM).
- Sequences each access with a ready handshake toward the memory.
- Drives a pipeline-wide stall while any access is outstanding.
- Sits between the Fetch/Memory units and the memory macro; the pipeline top consumes its stall in place of the external stall.

Parameters:
- width, 32, data and address width.
- STARVE_LIM, 4, consecutive DM grants after which a waiting IF request gets priority (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- start  input  1  reset; synchronous, active-low (start=0 resets on the clk edge).
- flush  input  1  pipeline flush (PC redirect); discards the in-flight or pending fetch.
- if_req  input  1  fetch request, level; held until if_valid.
- if_addr  input  width  fetch address.
- if_rdata  output  width  fetched instruction, registered.
- if_valid  output  1  one-cycle pulse; if_rdata valid.
- dm_rd  input  1  data load request, level.
- dm_wr  input  1  data store request, level; dm_rd and dm_wr are never both high.
- dm_addr  input  width  data address.
- dm_wdata  input  width  store data.
- dm_rdata  output  width  load data, registered.
- dm_valid  output  1  one-cycle pulse; load data valid or store done.
- mem_req  output  1  memory access request.
- mem_we  output  1  memory write enable.
- mem_addr  output  width  memory address.
- mem_wdata  output  width  memory write data.
- mem_rdata  input  width  memory read data, valid when mem_ready=1.
- mem_ready  input  1  memory completes the current access this cycle.
- stall  output  1  freeze PC and IF/ID; combinational.

Behaviour:
- Reset (start=0): state IDLE. All outputs 0: if_rdata, dm_rdata, if_valid, dm_valid, mem_req, mem_we, mem_addr, mem_wdata. starve_cnt=0, drop_if=0. Reset mid-access abandons the access with no response pulse.
- FSM states: IDLE, DM_BUSY, IF_BUSY.
- Pending requests: dm_pend = dm_rd|dm_wr; if_pend = if_req & ~flush.
- Arbitration in IDLE, evaluated each cycle:
  - If dm_pend and (~if_pend or starve_cnt<STARVE_LIM): go to DM_BUSY.
  - Else if if_pend: go to IF_BUSY.
  - Else: stay in IDLE.
  - Suppress a requester whose valid pulses this cycle; no back-to-back grant to the same stale request.
- On grant, latch mem_addr, mem_we (=dm_wr for DM, 0 for IF) and mem_wdata into registers, and set mem_req=1 from the next cycle.
- BUSY states:
  - mem_req and the latched fields stay stable until mem_ready=1.
  - On mem_ready: capture mem_rdata into if_rdata or dm_rdata; pulse the matching valid for exactly one cycle; drop mem_req; return to IDLE.
  - Minimum request-to-valid latency is 3 cycles with mem_ready tied high: grant edge, access cycle, valid.
- mem_ready while in IDLE is ignored.
- starve_cnt:
  - Increments (saturating at 15) on each DM grant while if_pend=1.
  - Clears on an IF grant or when if_pend=0.
- Flush:
  - In IF_BUSY, the memory access still completes (no abort), but if_valid is suppressed and if_rdata is not updated (drop_if set, cleared on completion).
  - No effect on DM accesses.
  - A flush coinciding with the IF completion cycle also suppresses that completion.
- stall = (if_req & ~if_valid) | (dm_pend & ~dm_valid). Combinational; 0 during reset.
- Stores: dm_rdata is unchanged; dm_valid still pulses.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, DM_BUSY=2'd1, IF_BUSY=2'd2) and the STARVE_LIM default.
- No sub-modules: a single FSM with a counter.

Test Plan:
- mem_ready tied 1; if_req=1 with if_addr=0x10 and mem_rdata=0x00500093 -> mem_req in cycle 1 with mem_addr=0x10, if_valid and if_rdata=0x00500093 in cycle 2; stall high through cycle 1, low when if_valid=1.
- if_req and dm_rd raised together, dm_addr=0x200 -> DM granted first (mem_addr=0x200, mem_we=0), then IF; dm_valid precedes if_valid.
- dm_wr with dm_addr=0x40, dm_wdata=0xDEADBEEF, mem_ready delayed 3 cycles -> mem_req/mem_we/mem_addr/mem_wdata stable for 4 cycles, dm_valid one pulse, dm_rdata unchanged.
- if_req held with dm_rd continuously re-asserted, STARVE_LIM=4 -> exactly 4 DM grants, then an IF grant; starve_cnt returns to 0.
- flush pulsed during IF_BUSY with mem_ready delayed 2 cycles -> access completes, no if_valid, if_rdata keeps its old value, FSM returns to IDLE.
- start=0 asserted mid DM_BUSY -> next edge: all outputs 0, no dm_valid; after release, a new if_req is served normally.
